// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution job scheduler.
package conv_pkg;

    localparam int KERNEL_TAPS = 9;

    typedef logic [KERNEL_TAPS-1:0][15:0] kernel_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_WGT = 3'd1,
        START  = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4
    } sched_state_e;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous result FIFO; DEPTH must be a power of two (>= 2).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sched_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/conv_sched.sv
// Job scheduler for the 2-channel 3x3 convolution engine: weight load, ifmap stream, result write-back.
// Build option CONV_SCHED_PERF_EN: when defined, perf_cycles counts busy cycles of the current job.
//
// state  | meaning
// IDLE   | waiting for a job descriptor
// LD_WGT | reading 9 packed weight words for the current output channel
// START  | one-cycle engine start pulse
// STREAM | reading ifmap words and forwarding them to the engine
// DRAIN  | waiting for eng_done and an empty result FIFO
module conv_sched
    import conv_pkg::*;
#(
    parameter int IFMAP_WORDS = 144,
    parameter int OFMAP_WORDS = 100,
    parameter int ADDR_W      = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_ifmap_base,
    input  logic [ADDR_W-1:0] job_wgt_base,
    input  logic [ADDR_W-1:0] job_ofmap_base,
    input  logic [7:0]        job_oc_num,
    output logic              mem_rd_req,
    input  logic              mem_rd_gnt,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_rvalid,
    input  logic [31:0]       mem_rd_rdata,
    output logic              mem_wr_req,
    input  logic              mem_wr_gnt,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [15:0]       mem_wr_data,
    output logic              eng_start,
    output logic [31:0]       eng_conv_num,
    output logic              eng_conv_num_valid,
    output logic [8:0][15:0]  eng_kernel_1,
    output logic [8:0][15:0]  eng_kernel_2,
    input  logic [15:0]       eng_dout,
    input  logic              eng_dout_valid,
    input  logic              eng_done,
    output logic              busy,
    output logic              irq_done,
    output logic              error,
    output logic [31:0]       perf_cycles
);

    localparam int RD_CNT_W  = $clog2(IFMAP_WORDS > KERNEL_TAPS ? IFMAP_WORDS : KERNEL_TAPS);
    localparam int OUT_CNT_W = $clog2(OFMAP_WORDS + 1);

    sched_state_e          state_q, state_d;
    logic [ADDR_W-1:0]     ifmap_base_q, wgt_base_q, ofmap_base_q;
    logic [7:0]            oc_q, oc_num_q;
    logic [RD_CNT_W-1:0]   rd_cnt_q;
    logic                  rd_req_q, rd_pend_q;
    logic                  done_seen_q;
    logic [OUT_CNT_W-1:0]  out_cnt_q;
    logic                  error_q;
    kernel_t               kern1_q, kern2_q;

    logic                  accept;
    logic                  rd_grant;
    logic                  rd_rsp;
    logic                  wgt_last;
    logic                  strm_last;
    logic                  drain_ok;
    logic                  more_oc;
    logic [ADDR_W-1:0]     wgt_rd_addr, ifm_rd_addr, ofm_wr_addr;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, overflow;
    logic [15:0]           fifo_dout;

    assign accept    = (state_q == IDLE) && job_valid;
    assign rd_grant  = rd_req_q && mem_rd_gnt;
    // Only a response to our own outstanding read counts; stray rvalids are ignored.
    assign rd_rsp    = mem_rd_rvalid && rd_pend_q;
    assign wgt_last  = (state_q == LD_WGT) && rd_rsp && (rd_cnt_q == RD_CNT_W'(KERNEL_TAPS - 1));
    assign strm_last = (state_q == STREAM) && rd_rsp && (rd_cnt_q == RD_CNT_W'(IFMAP_WORDS - 1));
    assign drain_ok  = (state_q == DRAIN) && done_seen_q && fifo_empty;
    assign more_oc   = (9'(oc_q) + 9'd1) < 9'(oc_num_q);

    assign wgt_rd_addr = wgt_base_q + ADDR_W'(oc_q) * ADDR_W'(KERNEL_TAPS) + ADDR_W'(rd_cnt_q);
    assign ifm_rd_addr = ifmap_base_q + ADDR_W'(rd_cnt_q);
    assign ofm_wr_addr = ofmap_base_q + ADDR_W'(oc_q) * ADDR_W'(OFMAP_WORDS) + ADDR_W'(out_cnt_q);

    always_comb begin
        state_d   = state_q;
        eng_start = 1'b0;
        irq_done  = 1'b0;
        case (state_q)
            IDLE:   if (job_valid) state_d = LD_WGT;
            LD_WGT: if (wgt_last) state_d = START;
            START: begin
                eng_start = 1'b1;
                state_d   = STREAM;
            end
            STREAM: if (strm_last) state_d = DRAIN;
            DRAIN: begin
                if (drain_ok) begin
                    if (more_oc) begin
                        state_d = LD_WGT;
                    end else begin
                        irq_done = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifmap_base_q <= '0;
            wgt_base_q   <= '0;
            ofmap_base_q <= '0;
            oc_q         <= '0;
            oc_num_q     <= '0;
            rd_cnt_q     <= '0;
            rd_req_q     <= 1'b0;
            rd_pend_q    <= 1'b0;
            done_seen_q  <= 1'b0;
            out_cnt_q    <= '0;
            error_q      <= 1'b0;
            kern1_q      <= '0;
            kern2_q      <= '0;
        end else begin
            if (accept) begin
                ifmap_base_q <= job_ifmap_base;
                wgt_base_q   <= job_wgt_base;
                ofmap_base_q <= job_ofmap_base;
                oc_num_q     <= (job_oc_num == 8'd0) ? 8'd1 : job_oc_num;
                oc_q         <= '0;
            end

            if (rd_grant) begin
                rd_req_q  <= 1'b0;
                rd_pend_q <= 1'b1;
            end
            if (rd_rsp && (state_q == LD_WGT || state_q == STREAM)) begin
                rd_pend_q <= 1'b0;
                rd_cnt_q  <= rd_cnt_q + 1'b1;
                if (!wgt_last && !strm_last) rd_req_q <= 1'b1;
            end

            if (state_q == LD_WGT && rd_rsp) begin
                for (int i = 0; i < KERNEL_TAPS; i++) begin
                    if (rd_cnt_q == RD_CNT_W'(i)) begin
                        kern1_q[i] <= mem_rd_rdata[15:0];
                        kern2_q[i] <= mem_rd_rdata[31:16];
                    end
                end
            end

            // Entering a read phase restarts the read sequence one cycle later.
            if (accept || (drain_ok && more_oc) || state_q == START) begin
                rd_req_q <= 1'b1;
                rd_cnt_q <= '0;
            end
            if (drain_ok && more_oc) oc_q <= oc_q + 8'd1;

            if (state_q == START) begin
                done_seen_q <= 1'b0;
                out_cnt_q   <= '0;
            end else begin
                if (eng_done && (state_q == STREAM || state_q == DRAIN)) done_seen_q <= 1'b1;
                if (fifo_pop) out_cnt_q <= out_cnt_q + 1'b1;
            end

            if (accept) begin
                error_q <= 1'b0;
            end else if (overflow || (drain_ok && out_cnt_q != OUT_CNT_W'(OFMAP_WORDS))) begin
                error_q <= 1'b1;
            end
        end
    end

    assign fifo_push = eng_dout_valid && (state_q != IDLE);
    assign fifo_pop  = mem_wr_req && mem_wr_gnt;
    assign overflow  = fifo_push && fifo_full && !fifo_pop;

    sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (eng_dout),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign job_ready          = (state_q == IDLE);
    assign busy               = (state_q != IDLE);
    assign error              = error_q;
    assign mem_rd_req         = rd_req_q;
    assign mem_rd_addr        = !rd_req_q ? '0 : ((state_q == LD_WGT) ? wgt_rd_addr : ifm_rd_addr);
    assign eng_conv_num_valid = (state_q == STREAM) && rd_rsp;
    assign eng_conv_num       = eng_conv_num_valid ? mem_rd_rdata : 32'd0;
    assign mem_wr_req         = !fifo_empty;
    assign mem_wr_data        = fifo_empty ? 16'd0 : fifo_dout;
    assign mem_wr_addr        = fifo_empty ? '0 : ofm_wr_addr;
    assign eng_kernel_1       = kern1_q;
    assign eng_kernel_2       = kern2_q;

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      perf_q <= '0;
        else if (accept) perf_q <= '0;
        else if (busy)   perf_q <= perf_q + 32'd1;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: SRAM, write-port and engine models with hand-computed expectations.
module tb_conv_sched;

    logic              clk;
    logic              rst_n;
    logic              job_valid;
    logic              job_ready;
    logic [15:0]       job_ifmap_base, job_wgt_base, job_ofmap_base;
    logic [7:0]        job_oc_num;
    logic              mem_rd_req, mem_rd_gnt, mem_rd_rvalid;
    logic [15:0]       mem_rd_addr;
    logic [31:0]       mem_rd_rdata;
    logic              mem_wr_req, mem_wr_gnt;
    logic [15:0]       mem_wr_addr, mem_wr_data;
    logic              eng_start;
    logic [31:0]       eng_conv_num;
    logic              eng_conv_num_valid;
    logic [8:0][15:0]  eng_kernel_1, eng_kernel_2;
    logic [15:0]       eng_dout;
    logic              eng_dout_valid, eng_done;
    logic              busy, irq_done, error;
    logic [31:0]       perf_cycles;

    int vecs = 0;
    int miss = 0;

    int rd_lat = 0;
    int wr_lat = 0;
    logic wr_hold = 1'b0;
    int rd_wait, wr_wait;

    int n_results = 100;
    int words, emitted;
    logic done_sent;
    logic mdl_valid, mdl_done;
    logic [15:0] mdl_data;
    logic man_mode = 1'b0;
    logic man_valid = 1'b0;
    logic [15:0] man_data = 16'd0;

    int irq_cnt = 0;
    int start_cnt = 0;
    int busy_cnt = 0;
    logic [15:0] rd_log[$];
    logic [15:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];

    conv_sched dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .job_valid          (job_valid),
        .job_ready          (job_ready),
        .job_ifmap_base     (job_ifmap_base),
        .job_wgt_base       (job_wgt_base),
        .job_ofmap_base     (job_ofmap_base),
        .job_oc_num         (job_oc_num),
        .mem_rd_req         (mem_rd_req),
        .mem_rd_gnt         (mem_rd_gnt),
        .mem_rd_addr        (mem_rd_addr),
        .mem_rd_rvalid      (mem_rd_rvalid),
        .mem_rd_rdata       (mem_rd_rdata),
        .mem_wr_req         (mem_wr_req),
        .mem_wr_gnt         (mem_wr_gnt),
        .mem_wr_addr        (mem_wr_addr),
        .mem_wr_data        (mem_wr_data),
        .eng_start          (eng_start),
        .eng_conv_num       (eng_conv_num),
        .eng_conv_num_valid (eng_conv_num_valid),
        .eng_kernel_1       (eng_kernel_1),
        .eng_kernel_2       (eng_kernel_2),
        .eng_dout           (eng_dout),
        .eng_dout_valid     (eng_dout_valid),
        .eng_done           (eng_done),
        .busy               (busy),
        .irq_done           (irq_done),
        .error              (error),
        .perf_cycles        (perf_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM: grant after rd_lat/wr_lat waiting cycles, read data one cycle after grant.
    assign mem_rd_gnt = mem_rd_req && (rd_wait >= rd_lat);
    assign mem_wr_gnt = mem_wr_req && !wr_hold && (wr_wait >= wr_lat);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_wait       <= 0;
            wr_wait       <= 0;
            mem_rd_rvalid <= 1'b0;
            mem_rd_rdata  <= 32'd0;
        end else begin
            rd_wait       <= (mem_rd_req && !mem_rd_gnt) ? rd_wait + 1 : 0;
            wr_wait       <= (mem_wr_req && !mem_wr_gnt) ? wr_wait + 1 : 0;
            mem_rd_rvalid <= mem_rd_req && mem_rd_gnt;
            mem_rd_rdata  <= {mem_rd_addr ^ 16'h5A5A, mem_rd_addr};
        end
    end

    // Engine: one result per stream word from word 44 on, up to n_results; done after all 144 words.
    assign eng_dout_valid = man_mode ? man_valid : mdl_valid;
    assign eng_dout       = man_mode ? man_data  : mdl_data;
    assign eng_done       = mdl_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words     <= 0;
            emitted   <= 0;
            done_sent <= 1'b1;
            mdl_valid <= 1'b0;
            mdl_done  <= 1'b0;
            mdl_data  <= 16'd0;
        end else begin
            mdl_valid <= 1'b0;
            mdl_done  <= 1'b0;
            if (eng_start) begin
                words     <= 0;
                emitted   <= 0;
                done_sent <= 1'b0;
            end else begin
                if (eng_conv_num_valid) begin
                    words <= words + 1;
                    if (words >= 44 && emitted < n_results) begin
                        mdl_valid <= 1'b1;
                        mdl_data  <= 16'h1000 + 16'(emitted);
                        emitted   <= emitted + 1;
                    end
                end
                if (words == 144 && !done_sent) begin
                    mdl_done  <= 1'b1;
                    done_sent <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (irq_done)  irq_cnt++;
        if (eng_start) start_cnt++;
        if (busy)      busy_cnt++;
        if (mem_rd_req && mem_rd_gnt) rd_log.push_back(mem_rd_addr);
        if (mem_wr_req && mem_wr_gnt) begin
            wr_addr_log.push_back(mem_wr_addr);
            wr_data_log.push_back(mem_wr_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic submit(input logic [15:0] ib, input logic [15:0] wb, input logic [15:0] ob,
                          input logic [7:0] ocn);
        @(negedge clk);
        job_ifmap_base = ib;
        job_wgt_base   = wb;
        job_ofmap_base = ob;
        job_oc_num     = ocn;
        job_valid      = 1'b1;
        @(negedge clk);
        job_valid      = 1'b0;
    endtask

    task automatic wait_irq(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (irq_done) seen = 1'b1;
        end
        chk({tag, "_irq_seen"}, 32'(seen), 1);
        if (seen) begin
            chk({tag, "_ready_at_irq"}, 32'(job_ready), 0);
            @(negedge clk);
            chk({tag, "_ready_after_irq"}, 32'(job_ready), 1);
        end
    endtask

    task automatic wait_reads(input string tag, input int n, input int budget);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (rd_log.size() >= n) hit = 1'b1;
        end
        chk({tag, "_reads_reached"}, 32'(hit), 1);
    endtask

    initial begin
        int rb, wb, ib0, sb, bb;
        int rv;
        logic [31:0] perf_snap;

        rst_n          = 1'b0;
        job_valid      = 1'b0;
        job_ifmap_base = 16'd0;
        job_wgt_base   = 16'd0;
        job_ofmap_base = 16'd0;
        job_oc_num     = 8'd0;

        repeat (3) @(negedge clk);
        chk("rst_rd_req",    32'(mem_rd_req), 0);
        chk("rst_rd_addr",   32'(mem_rd_addr), 0);
        chk("rst_wr_req",    32'(mem_wr_req), 0);
        chk("rst_eng_start", 32'(eng_start), 0);
        chk("rst_conv_vld",  32'(eng_conv_num_valid), 0);
        chk("rst_kernels",   32'(|{eng_kernel_1, eng_kernel_2}), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_irq",       32'(irq_done), 0);
        chk("rst_error",     32'(error), 0);
        chk("rst_perf",      perf_cycles, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_job_ready", 32'(job_ready), 1);

        // Job 1: single channel, zero-latency SRAM.
        rb = rd_log.size(); wb = wr_addr_log.size(); ib0 = irq_cnt; sb = start_cnt;
        n_results = 100;
        submit(16'h0200, 16'h0040, 16'h0400, 8'd1);
        chk("j1_accept_rd_req",  32'(mem_rd_req), 1);
        chk("j1_accept_rd_addr", 32'(mem_rd_addr), 'h40);
        rv = 0;
        for (int i = 0; i < 100 && rv < 9; i++) begin
            @(negedge clk);
            if (mem_rd_rvalid) rv++;
        end
        chk("j1_wgt_rvalids", rv, 9);
        @(negedge clk);
        chk("j1_start_latency", 32'(eng_start), 1);
        chk("j1_kernel1_0", 32'(eng_kernel_1[0]), 'h40);
        chk("j1_kernel2_8", 32'(eng_kernel_2[8]), 'h5A12);
        @(negedge clk);
        chk("j1_stream_rd_req",  32'(mem_rd_req), 1);
        chk("j1_stream_rd_addr", 32'(mem_rd_addr), 'h200);
        @(negedge clk);
        chk("j1_conv_vld", 32'(eng_conv_num_valid), 1);
        chk("j1_conv_num", eng_conv_num, 'h585A0200);
        job_wgt_base = 16'h0F00;
        job_valid    = 1'b1;
        repeat (3) @(negedge clk);
        chk("j1_busy_ignores_job", 32'(job_ready), 0);
        job_valid = 1'b0;
        wait_irq("j1", 3000);
        chk("j1_rd_count",   32'(rd_log.size() - rb), 153);
        chk("j1_rd_wgt_last", 32'(rd_log[rb + 8]), 'h48);
        chk("j1_rd_ifm_first", 32'(rd_log[rb + 9]), 'h200);
        chk("j1_rd_ifm_last", 32'(rd_log[rb + 152]), 'h28F);
        chk("j1_wr_count",   32'(wr_addr_log.size() - wb), 100);
        chk("j1_wr_first",   32'(wr_addr_log[wb]), 'h400);
        chk("j1_wr_last",    32'(wr_addr_log[wb + 99]), 'h463);
        chk("j1_wr_data0",   32'(wr_data_log[wb]), 'h1000);
        chk("j1_wr_data99",  32'(wr_data_log[wb + 99]), 'h1063);
        chk("j1_starts",     32'(start_cnt - sb), 1);
        chk("j1_irqs",       32'(irq_cnt - ib0), 1);
        chk("j1_error",      32'(error), 0);

        // Job 2: three output channels.
        rb = rd_log.size(); wb = wr_addr_log.size(); ib0 = irq_cnt; sb = start_cnt;
        submit(16'h0300, 16'h0100, 16'h0800, 8'd3);
        wait_irq("j2", 6000);
        chk("j2_rd_count", 32'(rd_log.size() - rb), 459);
        chk("j2_wgt_oc0",  32'(rd_log[rb]), 'h100);
        chk("j2_wgt_oc1",  32'(rd_log[rb + 153]), 'h109);
        chk("j2_wgt_oc2",  32'(rd_log[rb + 306]), 'h112);
        chk("j2_wr_count", 32'(wr_addr_log.size() - wb), 300);
        chk("j2_wr_oc0",   32'(wr_addr_log[wb]), 'h800);
        chk("j2_wr_oc1",   32'(wr_addr_log[wb + 100]), 'h864);
        chk("j2_wr_oc2",   32'(wr_addr_log[wb + 200]), 'h8C8);
        chk("j2_starts",   32'(start_cnt - sb), 3);
        chk("j2_irqs",     32'(irq_cnt - ib0), 1);
        chk("j2_error",    32'(error), 0);
        chk("j2_kernel1_0_hold", 32'(eng_kernel_1[0]), 'h112);
        chk("j2_kernel2_8_hold", 32'(eng_kernel_2[8]), 'h5B40);

        // Job 3: six back-to-back results while the write grant is withheld.
        rb = rd_log.size(); wb = wr_addr_log.size(); ib0 = irq_cnt;
        n_results = 0;
        submit(16'h1000, 16'h2000, 16'h3000, 8'd1);
        wait_reads("j3", rb + 30, 500);
        wr_hold  = 1'b1;
        man_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            man_valid = 1'b1;
            man_data  = 16'h00A0 + 16'(i);
            @(negedge clk);
            if (i == 0) chk("j3_push_to_wr_req", 32'(mem_wr_req), 1);
        end
        man_valid = 1'b0;
        man_mode  = 1'b0;
        chk("j3_overflow_error", 32'(error), 1);
        wr_hold = 1'b0;
        wait_irq("j3", 3000);
        chk("j3_wr_count", 32'(wr_addr_log.size() - wb), 4);
        chk("j3_wr_data0", 32'(wr_data_log[wb]), 'hA0);
        chk("j3_wr_data3", 32'(wr_data_log[wb + 3]), 'hA3);
        chk("j3_wr_addr3", 32'(wr_addr_log[wb + 3]), 'h3003);
        chk("j3_error_end", 32'(error), 1);
        chk("j3_irqs", 32'(irq_cnt - ib0), 1);

        // Job 4: engine emits only 99 results.
        wb = wr_addr_log.size(); ib0 = irq_cnt;
        n_results = 99;
        submit(16'h4000, 16'h4100, 16'h5000, 8'd0);
        chk("j4_error_cleared", 32'(error), 0);
        wait_irq("j4", 3000);
        chk("j4_wr_count", 32'(wr_addr_log.size() - wb), 99);
        chk("j4_wr_last",  32'(wr_addr_log[wb + 98]), 'h5062);
        chk("j4_error",    32'(error), 1);
        chk("j4_irqs",     32'(irq_cnt - ib0), 1);

        // Job 5: reset in the middle of the ifmap stream.
        rb = rd_log.size();
        n_results = 100;
        submit(16'h6000, 16'h6100, 16'h7000, 8'd1);
        wait_reads("j5", rb + 40, 500);
        ib0 = irq_cnt;
        rst_n = 1'b0;
        #1;
        chk("j5_rst_rd_req",   32'(mem_rd_req), 0);
        chk("j5_rst_wr_req",   32'(mem_wr_req), 0);
        chk("j5_rst_conv_vld", 32'(eng_conv_num_valid), 0);
        chk("j5_rst_kernels",  32'(|{eng_kernel_1, eng_kernel_2}), 0);
        chk("j5_rst_busy",     32'(busy), 0);
        chk("j5_rst_ready",    32'(job_ready), 1);
        chk("j5_rst_error",    32'(error), 0);
        chk("j5_rst_irq",      32'(irq_done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("j5_no_irq", 32'(irq_cnt - ib0), 0);

        // Job 6: clean job after reset with 2-cycle grant latency on both ports.
        rd_lat = 2;
        wr_lat = 2;
        wb = wr_addr_log.size(); ib0 = irq_cnt; bb = busy_cnt;
        submit(16'h8000, 16'h8100, 16'h9000, 8'd1);
        wait_irq("j6", 4000);
        chk("j6_wr_count", 32'(wr_addr_log.size() - wb), 100);
        chk("j6_wr_last",  32'(wr_addr_log[wb + 99]), 'h9063);
        chk("j6_error",    32'(error), 0);
        chk("j6_irqs",     32'(irq_cnt - ib0), 1);
`ifdef CONV_SCHED_PERF_EN
        chk("j6_perf", perf_cycles, 32'(busy_cnt - bb));
`else
        chk("j6_perf_off", perf_cycles, 0);
`endif
        perf_snap = perf_cycles;
        repeat (5) @(negedge clk);
        chk("j6_perf_hold", perf_cycles, perf_snap);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/conv_sched.md
# conv_sched

Job-level scheduler for the 2-channel 3x3 convolution engine. Accepts a job descriptor from the CPU-side register block and, for each output channel, fetches 9 packed weight words into the engine kernel registers, pulses the engine start, and streams the ifmap from shared SRAM. It captures every engine result into a small FIFO and writes it back to SRAM. It sits between the accelerator register file, the SRAM port arbiter and the convolution engine.

## Interface
- IFMAP_WORDS, 144, ifmap words streamed per output channel; each word is 32 bits, ch1 in [15:0], ch2 in [31:16]
- OFMAP_WORDS, 100, results expected per output channel
- ADDR_W, 16, SRAM word-address width
- FIFO_DEPTH, 4, result FIFO depth (power of 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- job_valid / job_ready  in/out  1  descriptor handshake; job_ready = (state == IDLE)
- job_ifmap_base, job_wgt_base, job_ofmap_base  in  ADDR_W  base addresses
- job_oc_num  in  8  output channels, 0 treated as 1
- mem_rd_req / mem_rd_gnt  out/in  1  read request, held until gnt
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_rvalid / mem_rd_rdata  in  1/32  read response
- mem_wr_req / mem_wr_gnt  out/in  1  write request, held until gnt
- mem_wr_addr / mem_wr_data  out  ADDR_W/16  write address and data
- eng_start  out  1  one-cycle engine start
- eng_conv_num / eng_conv_num_valid  out  32/1  ifmap stream to engine
- eng_kernel_1, eng_kernel_2  out  [8:0][15:0]  kernel registers
- eng_dout / eng_dout_valid  in  16/1  engine result
- eng_done  in  1  engine job-complete pulse
- busy  out  1  state != IDLE
- irq_done  out  1  one-cycle pulse at job end
- error  out  1  sticky; cleared on job accept
- perf_cycles  out  32  see Configuration

## Operation
- States: IDLE, LD_WGT, START, STREAM, DRAIN.
- IDLE: on job_valid, latch the descriptor, set oc = 0, clear error, and go to LD_WGT.
- LD_WGT: issue 9 reads at job_wgt_base + oc*9 + i, i = 0..8.
  - rdata[15:0] goes to eng_kernel_1[i]; rdata[31:16] goes to eng_kernel_2[i].
  - After the 9th rvalid, go to START.
- START: assert eng_start for one cycle, clear out_cnt, then go to STREAM.
- STREAM: issue IFMAP_WORDS reads at job_ifmap_base + j.
  - Each rvalid drives eng_conv_num = rdata and eng_conv_num_valid = 1 in the same cycle, combinationally from the response.
  - The engine has no backpressure.
  - After the last rvalid, go to DRAIN.
- DRAIN: wait until eng_done has been seen, the FIFO is empty and no write is pending.
  - If out_cnt != OFMAP_WORDS, set error.
  - If oc+1 < oc_num: increment oc and go to LD_WGT.
  - Otherwise pulse irq_done and go to IDLE.
- eng_done may arrive during STREAM or DRAIN; latch it in a flag cleared at START.
- Memory read port:
  - At most one read outstanding.
  - The next mem_rd_req is raised the cycle after rvalid.
  - rvalid outside a pending read is ignored.
- Result path:
  - Every eng_dout_valid pushes eng_dout into the FIFO in any non-IDLE state.
  - The FIFO head drives mem_wr_data at mem_wr_addr = job_ofmap_base + oc*OFMAP_WORDS + out_cnt.
  - Pop and out_cnt++ happen on mem_wr_gnt.
  - A push while the FIFO is full sets error and drops the data.
  - Simultaneous push and pop when full is legal and not an error.
- Arithmetic: address arithmetic is mod 2^ADDR_W, with wrap-around allowed silently. Counters are sized to their parameter and do not wrap within a job.
- eng_kernel_* hold their value from the end of LD_WGT through the next LD_WGT.

## Timing
- Reset values: all outputs 0; kernels 0; state IDLE; FIFO empty; error 0.
- Asynchronous reset mid-job aborts immediately, with no irq_done.
- Job accept to first mem_rd_req: 1 cycle.
- Last weight rvalid to eng_start: 1 cycle.
- eng_start to first stream mem_rd_req: 1 cycle.
- FIFO push to mem_wr_req: 1 cycle.
- irq_done is asserted in the cycle DRAIN exits; job_ready rises the next cycle.
- job_valid while busy is ignored (job_ready = 0).

## Configuration
- CONV_SCHED_PERF_EN defined: perf_cycles counts cycles with busy = 1.
  - It is cleared on job accept and holds its value after irq_done until the next accept.
- Not defined: perf_cycles is tied to 0 and no counter is built.

## Structure
- Shared package conv_pkg holds:
  - the state enum sched_state_e;
  - the constant KERNEL_TAPS = 9;
  - the packed type kernel_t = logic [8:0][15:0].
- One sub-module: sched_fifo, a synchronous FIFO with parameters DEPTH and WIDTH and outputs full/empty.

## Test plan
- Single job, oc_num = 1, zero-latency SRAM model:
  - Expect 9 weight reads at wgt_base..+8, one eng_start, 144 stream reads, and 100 writes at ofmap_base..+99.
  - Expect one irq_done and error = 0.
- oc_num = 3, wgt_base = 0x100, ofmap_base = 0x800:
  - Weights are read at 0x100, 0x109 and 0x112.
  - Writes start at 0x800, 0x864 and 0x8C8.
  - Expect 3 eng_start pulses and 1 irq_done.
- mem_wr_gnt withheld for 6 cycles while the engine emits 6 back-to-back results: error = 1 and exactly 4 of those results are written.
- Engine model emits 99 results then eng_done: error = 1 after DRAIN and the job still completes with irq_done.
- Assert rst_n low mid-STREAM: all outputs are 0 next cycle, job_ready = 1, no irq_done; a new job then completes cleanly.
- With CONV_SCHED_PERF_EN and 2-cycle grant latency: perf_cycles equals the bench-measured busy cycles. Without the macro, perf_cycles is always 0.
